// File: rtl/rom_fetch_arbiter.sv
// Shares one 16-bit memory read port between the M68K program ROM and the Z80 sound ROM.
// Each requester has a one-word fill buffer so repeat reads and Z80 odd-byte reads skip the port.
module rom_fetch_arbiter #(
    parameter int unsigned       ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] M68K_BASE = ADDR_W'(24'h000000),
    parameter logic [ADDR_W-1:0] Z80_BASE  = ADDR_W'(24'h020000)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              m68k_rom_cs,
    input  logic [22:0]       m68k_addr,
    output logic [15:0]       m68k_rom_data,
    output logic              m68k_rom_valid,
    input  logic              z80_rom_cs,
    input  logic [15:0]       z80_addr,
    output logic [7:0]        z80_rom_data,
    output logic              z80_rom_valid,
    output logic              z80_wait_n,
    input  logic              cache_flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data
);

    typedef enum logic [1:0] {IDLE, BUSY_M, BUSY_Z} state_t;

    state_t            r_state;
    logic              r_last_m;
    logic              r_flushed;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;

    logic [22:0]       r_m_tag;
    logic [15:0]       r_m_buf;
    logic              r_m_tv;
    logic              r_m_pend;
    logic              r_m_valid;
    logic [15:0]       r_m_data;

    logic [14:0]       r_z_tag;
    logic [15:0]       r_z_buf;
    logic              r_z_tv;
    logic              r_z_pend;
    logic              r_z_valid;
    logic [7:0]        r_z_data;

    logic              w_m_hit;
    logic              w_z_hit;
    logic              w_m_ack;
    logic              w_z_ack;
    logic              w_m_pend;
    logic              w_z_pend;
    logic [ADDR_W-1:0] w_m_mem_addr;
    logic [ADDR_W-1:0] w_z_mem_addr;

    assign w_m_hit  = m68k_rom_cs & r_m_tv & (r_m_tag == m68k_addr);
    assign w_z_hit  = z80_rom_cs & r_z_tv & (r_z_tag == z80_addr[15:1]);
    assign w_m_ack  = (r_state == BUSY_M) & mem_ack;
    assign w_z_ack  = (r_state == BUSY_Z) & mem_ack;

    // A requester being served is masked so the fill cycle cannot re-arm its own request.
    assign w_m_pend = m68k_rom_cs & ~w_m_hit & ~r_m_valid & (r_state != BUSY_M);
    assign w_z_pend = z80_rom_cs & ~w_z_hit & ~r_z_valid & (r_state != BUSY_Z);

    assign w_m_mem_addr = M68K_BASE + ADDR_W'({m68k_addr, 1'b0});
    assign w_z_mem_addr = Z80_BASE + ADDR_W'({z80_addr[15:1], 1'b0});

    assign m68k_rom_data  = r_m_data;
    assign m68k_rom_valid = r_m_valid;
    assign z80_rom_data   = r_z_data;
    assign z80_rom_valid  = r_z_valid;
    assign z80_wait_n     = ~(z80_rom_cs & ~r_z_valid);
    assign mem_req        = r_mem_req;
    assign mem_addr       = r_mem_addr;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_m   <= 1'b0;
            r_flushed  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_m_tag    <= '0;
            r_m_buf    <= '0;
            r_m_tv     <= 1'b0;
            r_m_pend   <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_z_tag    <= '0;
            r_z_buf    <= '0;
            r_z_tv     <= 1'b0;
            r_z_pend   <= 1'b0;
            r_z_valid  <= 1'b0;
            r_z_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // When both wait, the requester that did not win last time goes first.
                    if (r_m_pend && (!r_z_pend || !r_last_m)) begin
                        r_state    <= BUSY_M;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_m_mem_addr;
                        r_last_m   <= 1'b1;
                        r_m_tag    <= m68k_addr;
                        r_m_tv     <= 1'b0;
                        r_flushed  <= 1'b0;
                    end else if (r_z_pend) begin
                        r_state    <= BUSY_Z;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_z_mem_addr;
                        r_last_m   <= 1'b0;
                        r_z_tag    <= z80_addr[15:1];
                        r_z_tv     <= 1'b0;
                        r_flushed  <= 1'b0;
                    end
                end
                BUSY_M: begin
                    if (mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_m_buf   <= mem_data;
                        r_m_tv    <= ~(cache_flush | r_flushed);
                        r_flushed <= 1'b0;
                    end else if (cache_flush) begin
                        r_flushed <= 1'b1;
                    end
                end
                BUSY_Z: begin
                    if (mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_z_buf   <= mem_data;
                        r_z_tv    <= ~(cache_flush | r_flushed);
                        r_flushed <= 1'b0;
                    end else if (cache_flush) begin
                        r_flushed <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_m_pend  <= w_m_pend;
            r_z_pend  <= w_z_pend;
            r_m_valid <= m68k_rom_cs & (r_m_valid | w_m_hit | w_m_ack);
            r_z_valid <= z80_rom_cs & (r_z_valid | w_z_hit | w_z_ack);

            if (w_m_ack)
                r_m_data <= mem_data;
            else if (w_m_hit && !r_m_valid)
                r_m_data <= r_m_buf;

            if (w_z_ack)
                r_z_data <= z80_addr[0] ? mem_data[15:8] : mem_data[7:0];
            else if (w_z_hit && !r_z_valid)
                r_z_data <= z80_addr[0] ? r_z_buf[15:8] : r_z_buf[7:0];

            // Flush overrides any tag-valid update made above in the same cycle.
            if (cache_flush) begin
                r_m_tv <= 1'b0;
                r_z_tv <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Scoreboard bench for rom_fetch_arbiter: stimulus queues expected memory addresses and read data,
// monitors pop and compare whenever mem_req rises or a valid rises.
module tb_rom_fetch_arbiter;

    localparam logic [23:0] M_BASE = 24'h000000;
    localparam logic [23:0] Z_BASE = 24'h020000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        m68k_rom_cs;
    logic [22:0] m68k_addr;
    logic [15:0] m68k_rom_data;
    logic        m68k_rom_valid;
    logic        z80_rom_cs;
    logic [15:0] z80_addr;
    logic [7:0]  z80_rom_data;
    logic        z80_rom_valid;
    logic        z80_wait_n;
    logic        cache_flush;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_req    = 0;
    bit flush_on_ack = 1'b0;

    logic [23:0] q_mem[$];
    logic [15:0] q_m[$];
    logic [7:0]  q_z[$];

    rom_fetch_arbiter #(
        .ADDR_W    (24),
        .M68K_BASE (M_BASE),
        .Z80_BASE  (Z_BASE)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .m68k_rom_cs    (m68k_rom_cs),
        .m68k_addr      (m68k_addr),
        .m68k_rom_data  (m68k_rom_data),
        .m68k_rom_valid (m68k_rom_valid),
        .z80_rom_cs     (z80_rom_cs),
        .z80_addr       (z80_addr),
        .z80_rom_data   (z80_rom_data),
        .z80_rom_valid  (z80_rom_valid),
        .z80_wait_n     (z80_wait_n),
        .cache_flush    (cache_flush),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        if (a == 24'h000200) return 16'hBEEF;
        if (a == 24'h021234) return 16'hA55A;
        return a[15:0] ^ 16'h6C93;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h required nothing (t=%0t)", name, act, $time);
    endtask

    // Memory model: acknowledges 4 clocks after mem_req rises; optionally pulses flush with the ack.
    initial begin
        logic [23:0] req_addr;
        mem_ack     = 1'b0;
        mem_data    = '0;
        cache_flush = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mem_req && !reset) begin
                req_addr = mem_addr;
                repeat (3) @(negedge clk_sys);
                mem_ack     = 1'b1;
                mem_data    = mem_word(req_addr);
                cache_flush = flush_on_ack;
                @(negedge clk_sys);
                mem_ack     = 1'b0;
                cache_flush = 1'b0;
            end
        end
    end

    initial begin : mon_mem
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mem_req && !prev) begin
                n_req++;
                if (q_mem.size() == 0) unexpected("unexpected_mem_req", 32'(mem_addr));
                else check("mem_addr", 32'(mem_addr), 32'(q_mem.pop_front()));
            end
            prev = mem_req;
        end
    end

    initial begin : mon_m
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (m68k_rom_valid && !prev) begin
                if (q_m.size() == 0) unexpected("unexpected_m68k_valid", 32'(m68k_rom_data));
                else check("m68k_rom_data", 32'(m68k_rom_data), 32'(q_m.pop_front()));
            end
            prev = m68k_rom_valid;
        end
    end

    initial begin : mon_z
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (z80_rom_valid && !prev) begin
                if (q_z.size() == 0) unexpected("unexpected_z80_valid", 32'(z80_rom_data));
                else check("z80_rom_data", 32'(z80_rom_data), 32'(q_z.pop_front()));
            end
            prev = z80_rom_valid;
        end
    end

    task automatic m_read(input logic [22:0] a, input int exp_lat, input bit push);
        int cnt = 0;
        if (push) q_mem.push_back(M_BASE + 24'({a, 1'b0}));
        q_m.push_back(mem_word(M_BASE + 24'({a, 1'b0})));
        m68k_addr   = a;
        m68k_rom_cs = 1'b1;
        do begin
            @(negedge clk_sys);
            cnt++;
        end while (!m68k_rom_valid && cnt < 40);
        if (!m68k_rom_valid) check("m68k_valid_timeout", 32'(m68k_rom_valid), 32'd1);
        else if (exp_lat != 0) check("m68k_latency", 32'(cnt), 32'(exp_lat));
        m68k_rom_cs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic z_read(input logic [15:0] a, input int exp_lat, input int exp_wait, input bit push);
        int cnt = 0;
        int wcnt = 0;
        logic [15:0] w;
        w = mem_word(Z_BASE + 24'({a[15:1], 1'b0}));
        if (push) q_mem.push_back(Z_BASE + 24'({a[15:1], 1'b0}));
        q_z.push_back(a[0] ? w[15:8] : w[7:0]);
        z80_addr   = a;
        z80_rom_cs = 1'b1;
        do begin
            @(negedge clk_sys);
            cnt++;
            if (!z80_rom_valid && !z80_wait_n) wcnt++;
        end while (!z80_rom_valid && cnt < 40);
        if (!z80_rom_valid) check("z80_valid_timeout", 32'(z80_rom_valid), 32'd1);
        else if (exp_lat != 0) begin
            check("z80_latency", 32'(cnt), 32'(exp_lat));
            check("z80_wait_cycles", 32'(wcnt), 32'(exp_wait));
        end
        z80_rom_cs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_m68k_data"}, 32'(m68k_rom_data), 32'd0);
        check({tag, "_m68k_valid"}, 32'(m68k_rom_valid), 32'd0);
        check({tag, "_z80_data"}, 32'(z80_rom_data), 32'd0);
        check({tag, "_z80_valid"}, 32'(z80_rom_valid), 32'd0);
        check({tag, "_z80_wait_n"}, 32'(z80_wait_n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int t;
        int req_before;
        reset       = 1'b1;
        m68k_rom_cs = 1'b0;
        m68k_addr   = '0;
        z80_rom_cs  = 1'b0;
        z80_addr    = '0;
        repeat (3) @(negedge clk_sys);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk_sys);

        // M68K miss then hit on the same word
        m_read(23'h000100, 6, 1'b1);
        req_before = n_req;
        m_read(23'h000100, 1, 1'b0);
        check("m68k_hit_no_req", 32'(n_req), 32'(req_before));

        // Z80 even byte miss, then odd byte of the same word from the buffer
        z_read(16'h1234, 6, 5, 1'b1);
        req_before = n_req;
        z_read(16'h1235, 1, 0, 1'b0);
        check("z80_odd_byte_no_req", 32'(n_req), 32'(req_before));

        // Both requesters from reset: grants alternate M,Z,M,Z over 8 misses
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_mem.push_back(M_BASE + 24'({23'h000400 + 23'(i), 1'b0}));
            q_mem.push_back(Z_BASE + 24'h000800 + 24'(2 * i));
        end
        fork
            begin
                for (int i = 0; i < 4; i++) m_read(23'h000400 + 23'(i), 0, 1'b0);
            end
            begin
                for (int j = 0; j < 4; j++) z_read(16'h0801 + 16'(2 * j), 0, 0, 1'b0);
            end
        join
        check("alternation_all_served", 32'(q_mem.size()), 32'd0);

        // Z80 drops cs mid-fetch: fill completes silently, re-read hits
        q_mem.push_back(Z_BASE + 24'h000100);
        z80_addr   = 16'h0100;
        z80_rom_cs = 1'b1;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!mem_req && t < 20);
        z80_rom_cs = 1'b0;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (mem_req && t < 20);
        check("abort_fetch_done", 32'(mem_req), 32'd0);
        @(negedge clk_sys);
        check("abort_no_valid", 32'(z80_rom_valid), 32'd0);
        req_before = n_req;
        z_read(16'h0100, 1, 0, 1'b0);
        check("abort_reread_no_req", 32'(n_req), 32'(req_before));

        // Flush coincident with the fill ack: data still returned, next access misses
        flush_on_ack = 1'b1;
        m_read(23'h000010, 6, 1'b1);
        flush_on_ack = 1'b0;
        req_before = n_req;
        m_read(23'h000010, 6, 1'b1);
        check("flush_forces_refetch", 32'(n_req), 32'(req_before + 1));

        // Reset while BUSY_Z, then the late ack arrives while idle
        q_mem.push_back(Z_BASE + 24'h000300);
        z80_addr   = 16'h0300;
        z80_rom_cs = 1'b1;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!mem_req && t < 20);
        @(negedge clk_sys);
        reset      = 1'b1;
        z80_rom_cs = 1'b0;
        #1;
        check_idle_outputs("midfetch_reset");
        @(negedge clk_sys);
        reset = 1'b0;
        req_before = n_req;
        repeat (3) @(negedge clk_sys);
        check("stray_ack_no_req", 32'(mem_req), 32'd0);
        check("stray_ack_no_valid", 32'(z80_rom_valid), 32'd0);
        z_read(16'h0300, 6, 5, 1'b1);
        check("stray_ack_no_fill", 32'(n_req), 32'(req_before + 1));

        repeat (4) @(negedge clk_sys);
        check("q_mem_drained", 32'(q_mem.size()), 32'd0);
        check("q_m_drained", 32'(q_m.size()), 32'd0);
        check("q_z_drained", 32'(q_z.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
